wb_arbiter_mux: RTL and testbench

Self-arbitrating Wishbone B4 pipelined multiplexer: COUNT controllers share one peripheral bus, with no external grant logic. An internal arbiter (fixed-priority or round-robin) owns the grant, holds it for the whole bus cycle and limits in-flight requests. Replaces the externally-granted demux between the SPI/CPU/video controllers and the shared memory bus.

---
 rtl/wb_arbiter_mux.sv | 135 +++++++++++++
 tb/tb_wb_arbiter_mux.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_mux.sv
// Self-arbitrating Wishbone B4 pipelined multiplexer: COUNT controllers share one bus
// through an internal fixed-priority or round-robin arbiter with an in-flight strobe limit.
module wb_arbiter_mux #(
  parameter int unsigned COUNT           = 2,
  parameter int unsigned ROUND_ROBIN     = 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned WB_ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  localparam int unsigned GW = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic                                  wb_clock_i,
  input  logic                                  wb_reset_i,
  input  logic [COUNT-1:0]                      wbc_cycle_i,
  input  logic [COUNT-1:0]                      wbc_strobe_i,
  input  logic [COUNT-1:0]                      wbc_we_i,
  input  logic [COUNT-1:0][WB_ADDR_WIDTH-1:0]   wbc_addr_i,
  input  logic [COUNT-1:0][DATA_WIDTH-1:0]      wbc_dout_i,
  output logic [COUNT-1:0][DATA_WIDTH-1:0]      wbc_din_o,
  output logic [COUNT-1:0]                      wbc_stall_o,
  output logic [COUNT-1:0]                      wbc_ack_o,
  output logic                                  wb_cycle_o,
  output logic                                  wb_strobe_o,
  output logic                                  wb_we_o,
  output logic [WB_ADDR_WIDTH-1:0]              wb_addr_o,
  output logic [DATA_WIDTH-1:0]                 wb_dout_o,
  input  logic [DATA_WIDTH-1:0]                 wb_din_i,
  input  logic                                  wb_stall_i,
  input  logic                                  wb_ack_i,
  input  logic                                  pause_i,
  output logic [GW-1:0]                         grant_o,
  output logic                                  grant_valid_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]    state, state_nx;
  logic [GW-1:0] grant, grant_nx;
  logic [GW-1:0] last, last_nx;
  logic [GW-1:0] winner, cand;
  logic [CW-1:0] outstanding, outstanding_nx;
  logic          found;
  logic          at_max, below_max;
  logic          accept, ack_dec;

  assign at_max    = (outstanding == CW'(MAX_OUTSTANDING));
  assign below_max = (outstanding < CW'(MAX_OUTSTANDING));
  assign accept    = wb_strobe_o & ~wb_stall_i;
  assign ack_dec   = wb_ack_i & (outstanding != '0);

  assign grant_o   = grant;
  assign wbc_din_o = {COUNT{wb_din_i}};

  // Winner search: lowest index, or rotating from the slot after the last winner
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < COUNT; k++) begin
      if (ROUND_ROBIN != 0) begin
        cand = GW'((32'(last) + k + 32'd1) % COUNT);
      end else begin
        cand = GW'(k);
      end
      if (!found && wbc_cycle_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      state       <= ST_IDLE;
      grant       <= '0;
      last        <= GW'(COUNT - 1);
      outstanding <= '0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      last        <= last_nx;
      outstanding <= outstanding_nx;
    end
  end

  // Next state and bus/controller routing
  always_comb begin
    state_nx       = state;
    grant_nx       = grant;
    last_nx        = last;
    outstanding_nx = outstanding;
    wb_cycle_o     = 1'b0;
    wb_strobe_o    = 1'b0;
    wb_we_o        = 1'b0;
    wb_addr_o      = '0;
    wb_dout_o      = '0;
    wbc_stall_o    = '1;
    wbc_ack_o      = '0;
    grant_valid_o  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (|wbc_cycle_i) begin
          state_nx = ST_GRANT;
          grant_nx = winner;
          last_nx  = winner;
        end
      end
      ST_GRANT: begin
        grant_valid_o      = 1'b1;
        wb_cycle_o         = wbc_cycle_i[grant];
        wb_we_o            = wbc_we_i[grant];
        wb_addr_o          = wbc_addr_i[grant];
        wb_dout_o          = wbc_dout_i[grant];
        wb_strobe_o        = wbc_strobe_i[grant] & ~pause_i & below_max;
        wbc_stall_o[grant] = pause_i | wb_stall_i | at_max;
        wbc_ack_o[grant]   = wb_ack_i;
        // Dropping CYC aborts the cycle; acks still in flight are discarded
        if (!wbc_cycle_i[grant]) begin
          state_nx       = ST_IDLE;
          outstanding_nx = '0;
        end else if (accept && !ack_dec) begin
          outstanding_nx = outstanding + CW'(1);
        end else if (!accept && ack_dec) begin
          outstanding_nx = outstanding - CW'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_mux.sv
// Bench for wb_arbiter_mux: directed arbitration/limit scenarios plus randomized traffic
// checked against a cycle-level behavioural model of both arbitration policies.
module tb_wb_arbiter_mux;

  localparam int unsigned N    = 3;
  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 32;
  localparam int          MAXO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [N-1:0]          b_cyc, b_stb, b_we;
  logic [N-1:0][AW-1:0]  b_addr;
  logic [N-1:0][DW-1:0]  b_dout;
  logic [DW-1:0]         b_din;
  logic                  b_stall, b_ack, b_pause;

  logic [N-1:0][DW-1:0]  f_din, r_din;
  logic [N-1:0]          f_stall, f_ack, r_stall, r_ack;
  logic                  f_cyc, f_stb, f_we, r_cyc, r_stb, r_we;
  logic [AW-1:0]         f_addr, r_addr;
  logic [DW-1:0]         f_dout, r_dout;
  logic [1:0]            f_grant, r_grant;
  logic                  f_gv, r_gv;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  wb_arbiter_mux #(.COUNT(N), .ROUND_ROBIN(0), .MAX_OUTSTANDING(MAXO),
                   .WB_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_fp (
    .wb_clock_i(clk), .wb_reset_i(rst),
    .wbc_cycle_i(b_cyc), .wbc_strobe_i(b_stb), .wbc_we_i(b_we),
    .wbc_addr_i(b_addr), .wbc_dout_i(b_dout), .wbc_din_o(f_din),
    .wbc_stall_o(f_stall), .wbc_ack_o(f_ack),
    .wb_cycle_o(f_cyc), .wb_strobe_o(f_stb), .wb_we_o(f_we),
    .wb_addr_o(f_addr), .wb_dout_o(f_dout), .wb_din_i(b_din),
    .wb_stall_i(b_stall), .wb_ack_i(b_ack), .pause_i(b_pause),
    .grant_o(f_grant), .grant_valid_o(f_gv)
  );

  wb_arbiter_mux #(.COUNT(N), .ROUND_ROBIN(1), .MAX_OUTSTANDING(MAXO),
                   .WB_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut_rr (
    .wb_clock_i(clk), .wb_reset_i(rst),
    .wbc_cycle_i(b_cyc), .wbc_strobe_i(b_stb), .wbc_we_i(b_we),
    .wbc_addr_i(b_addr), .wbc_dout_i(b_dout), .wbc_din_o(r_din),
    .wbc_stall_o(r_stall), .wbc_ack_o(r_ack),
    .wb_cycle_o(r_cyc), .wb_strobe_o(r_stb), .wb_we_o(r_we),
    .wb_addr_o(r_addr), .wb_dout_o(r_dout), .wb_din_i(b_din),
    .wb_stall_i(b_stall), .wb_ack_i(b_ack), .pause_i(b_pause),
    .grant_o(r_grant), .grant_valid_o(r_gv)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; b_cyc = '0; b_stb = '0; b_ack = 1'b0; b_stall = 1'b0; b_pause = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    settle();
    n_vec++;
    if ({f_cyc, f_stb, f_gv, f_grant, f_stall, f_ack} !== {1'b0, 1'b0, 1'b0, 2'd0, 3'b111, 3'b000}) begin
      n_err++;
      $display("FAIL reset_idle_fp: got %b want %b", {f_cyc, f_stb, f_gv, f_grant, f_stall, f_ack}, 11'b00000111000);
    end
    n_vec++;
    if ({r_cyc, r_stb, r_gv, r_grant, r_stall, r_ack} !== {1'b0, 1'b0, 1'b0, 2'd0, 3'b111, 3'b000}) begin
      n_err++;
      $display("FAIL reset_idle_rr: got %b want %b", {r_cyc, r_stb, r_gv, r_grant, r_stall, r_ack}, 11'b00000111000);
    end
    // Controller 1 builds up two outstanding strobes, then reset lands mid-burst
    b_cyc = 3'b010;
    tick();
    b_stb = 3'b010;
    settle();
    n_vec++;
    if ({r_gv, r_grant, r_stb} !== {1'b1, 2'd1, 1'b1}) begin
      n_err++;
      $display("FAIL reset_burst_start: got %b want %b", {r_gv, r_grant, r_stb}, 4'b1011);
    end
    tick();
    tick();
    n_vec++;
    if ({r_stb, r_stall[1]} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_burst_full: got stb/stall %b want %b", {r_stb, r_stall[1]}, 2'b01);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; b_cyc = '0; b_stb = '0; b_ack = 1'b1;
    settle();
    n_vec++;
    if ({r_cyc, r_stb, r_gv, r_grant, r_stall, r_ack} !== {1'b0, 1'b0, 1'b0, 2'd0, 3'b111, 3'b000}) begin
      n_err++;
      $display("FAIL reset_midburst_rr: got %b want %b", {r_cyc, r_stb, r_gv, r_grant, r_stall, r_ack}, 11'b00000111000);
    end
    n_vec++;
    if ({f_gv, f_ack} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_midburst_fp: got gv/ack %b want %b", {f_gv, f_ack}, 4'b0000);
    end
    tick();
    b_ack = 1'b0;
  endtask

  task automatic test_fixed_priority();
    pulse_reset();
    b_cyc = 3'b110;
    settle();
    n_vec++;
    if (f_gv !== 1'b0) begin
      n_err++;
      $display("FAIL fp_latency: got gv %b want 0", f_gv);
    end
    tick();
    n_vec++;
    if ({f_gv, f_grant, f_cyc} !== {1'b1, 2'd1, 1'b1}) begin
      n_err++;
      $display("FAIL fp_first_grant: got %b want %b", {f_gv, f_grant, f_cyc}, 4'b1011);
    end
    b_cyc = 3'b100;
    settle();
    n_vec++;
    if ({f_gv, f_cyc} !== 2'b10) begin
      n_err++;
      $display("FAIL fp_drop: got gv/cyc %b want 10", {f_gv, f_cyc});
    end
    tick();
    n_vec++;
    if (f_gv !== 1'b0) begin
      n_err++;
      $display("FAIL fp_dead_cycle: got gv %b want 0", f_gv);
    end
    tick();
    n_vec++;
    if ({f_gv, f_grant, f_cyc} !== {1'b1, 2'd2, 1'b1}) begin
      n_err++;
      $display("FAIL fp_second_grant: got %b want %b", {f_gv, f_grant, f_cyc}, 4'b1101);
    end
    b_cyc = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_g [4] = '{0, 1, 2, 0};
    rst = 1'b1; b_cyc = 3'b111; b_stb = '0; b_ack = 1'b0; b_stall = 1'b0; b_pause = 1'b0;
    for (int i = 0; i < N; i++) b_addr[i] = AW'(16'h1000 + i);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int o;
      logic [N-1:0] oh;
      o  = exp_g[k];
      oh = '0;
      oh[o] = 1'b1;
      tick();
      n_vec++;
      if ({r_gv, r_grant, r_stall, r_addr} !== {1'b1, 2'(o), ~oh, b_addr[o]}) begin
        n_err++;
        $display("FAIL rr_grant_%0d: got gv=%b grant=%0d stall=%b addr=%h want grant=%0d stall=%b addr=%h",
                 k, r_gv, r_grant, r_stall, r_addr, o, ~oh, b_addr[o]);
      end
      b_stb[o] = 1'b1;
      settle();
      n_vec++;
      if (r_stb !== 1'b1) begin
        n_err++;
        $display("FAIL rr_strobe_%0d: got %b want 1", k, r_stb);
      end
      tick();
      b_stb = '0; b_ack = 1'b1;
      settle();
      n_vec++;
      if (r_ack !== oh) begin
        n_err++;
        $display("FAIL rr_ack_%0d: got %b want %b", k, r_ack, oh);
      end
      tick();
      b_ack = 1'b0; b_cyc[o] = 1'b0;
      tick();
      b_cyc = 3'b111;
      settle();
      n_vec++;
      if (r_gv !== 1'b0) begin
        n_err++;
        $display("FAIL rr_dead_%0d: got gv %b want 0", k, r_gv);
      end
    end
    b_cyc = '0;
    tick();
  endtask

  task automatic test_outstanding_limit();
    int due[$];
    int inflight = 0;
    int remaining = 4;
    int accepted = 0;
    logic exp_stb, exp_stall;
    pulse_reset();
    b_cyc = 3'b001;
    tick();
    for (int t = 0; t < 14; t++) begin
      b_stb = {2'b00, remaining > 0};
      b_ack = (due.size() > 0) && (due[0] == t);
      settle();
      exp_stb   = (remaining > 0) && (inflight < MAXO);
      exp_stall = (inflight == MAXO);
      n_vec++;
      if ({r_stb, r_stall[0], r_ack[0], f_stb} !== {exp_stb, exp_stall, b_ack, exp_stb}) begin
        n_err++;
        $display("FAIL limit_t%0d: got stb/stall/ack/fpstb %b want %b", t,
                 {r_stb, r_stall[0], r_ack[0], f_stb}, {exp_stb, exp_stall, b_ack, exp_stb});
      end
      if (r_stb && !r_stall[0]) accepted++;
      if (b_ack) begin
        void'(due.pop_front());
        inflight--;
      end
      if (exp_stb) begin
        remaining--;
        due.push_back(t + 3);
        inflight++;
      end
      tick();
    end
    n_vec++;
    if (accepted != 4) begin
      n_err++;
      $display("FAIL limit_total: got %0d accepted want 4", accepted);
    end
    b_cyc = '0; b_stb = '0; b_ack = 1'b0;
    tick();
  endtask

  task automatic test_pause_accept();
    pulse_reset();
    b_cyc = 3'b010;
    tick();
    b_stb = 3'b010;
    settle();
    n_vec++;
    if (r_stb !== 1'b1) begin
      n_err++;
      $display("FAIL pa_first: got stb %b want 1", r_stb);
    end
    tick();
    b_ack = 1'b1;
    settle();
    n_vec++;
    if ({r_stb, r_ack} !== 4'b1010) begin
      n_err++;
      $display("FAIL pa_accept_ack: got stb/ack %b want 1010", {r_stb, r_ack});
    end
    tick();
    b_stb = '0;
    tick();
    settle();
    n_vec++;
    if (r_ack !== 3'b010) begin
      n_err++;
      $display("FAIL pa_stray_ack: got ack %b want 010", r_ack);
    end
    tick();
    // Counter must now be 0: two strobes fit, the third is held off
    b_ack = 1'b0; b_stb = 3'b010;
    settle();
    n_vec++;
    if ({r_stb, r_stall[1]} !== 2'b10) begin
      n_err++;
      $display("FAIL pa_refill1: got stb/stall %b want 10", {r_stb, r_stall[1]});
    end
    tick();
    n_vec++;
    if ({r_stb, r_stall[1]} !== 2'b10) begin
      n_err++;
      $display("FAIL pa_refill2: got stb/stall %b want 10", {r_stb, r_stall[1]});
    end
    tick();
    n_vec++;
    if ({r_stb, r_stall} !== 4'b0111) begin
      n_err++;
      $display("FAIL pa_full: got stb/stall %b want 0111", {r_stb, r_stall});
    end
    b_stb = '0; b_ack = 1'b1;
    tick();
    tick();
    b_ack = 1'b0; b_stb = 3'b010; b_pause = 1'b1;
    settle();
    n_vec++;
    if ({r_stb, r_stall[1], r_grant, r_gv, f_stb} !== {1'b0, 1'b1, 2'd1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL pa_paused: got %b want %b", {r_stb, r_stall[1], r_grant, r_gv, f_stb}, 6'b010110);
    end
    tick();
    b_pause = 1'b0;
    settle();
    n_vec++;
    if ({r_stb, r_stall[1], f_stb} !== 3'b101) begin
      n_err++;
      $display("FAIL pa_resume: got %b want 101", {r_stb, r_stall[1], f_stb});
    end
    tick();
    b_stb = '0; b_cyc = '0;
    tick();
  endtask

  task automatic test_random();
    int m_owner [2];
    int m_last  [2];
    int m_outs  [2];
    pulse_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_last[d] = N - 1; m_outs[d] = 0;
    end
    for (int t = 0; t < 800; t++) begin
      rst = ($urandom_range(99) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(9) == 0) b_cyc[i] = ~b_cyc[i];
        b_addr[i] = AW'($urandom);
        b_dout[i] = $urandom;
      end
      b_stb   = N'($urandom);
      b_we    = N'($urandom);
      b_din   = $urandom;
      b_stall = ($urandom_range(3) == 0);
      b_ack   = ($urandom_range(2) == 0);
      b_pause = ($urandom_range(9) == 0);
      settle();
      for (int d = 0; d < 2; d++) begin
        logic [59:0] got, exp;
        logic [N-1:0] e_stall, e_ack;
        logic e_stb;
        int o;
        o = m_owner[d];
        e_stall = '1; e_ack = '0; e_stb = 1'b0;
        if (o >= 0) begin
          e_stb = b_stb[o] && !b_pause && (m_outs[d] < MAXO);
          e_stall[o] = b_pause || b_stall || (m_outs[d] == MAXO);
          e_ack[o] = b_ack;
          exp = {b_cyc[o], e_stb, b_we[o], b_addr[o], b_dout[o], e_stall, e_ack, 1'b1, 2'(o)};
          if (d == 0) got = {f_cyc, f_stb, f_we, f_addr, f_dout, f_stall, f_ack, f_gv, f_grant};
          else        got = {r_cyc, r_stb, r_we, r_addr, r_dout, r_stall, r_ack, r_gv, r_grant};
        end else begin
          exp = {1'b0, 1'b0, 1'b0, 16'h0, 32'h0, e_stall, e_ack, 1'b0, 2'd0};
          if (d == 0) got = {f_cyc, f_stb, 1'b0, 16'h0, 32'h0, f_stall, f_ack, f_gv, 2'd0};
          else        got = {r_cyc, r_stb, 1'b0, 16'h0, 32'h0, r_stall, r_ack, r_gv, 2'd0};
        end
        n_vec++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL rand_%s_t%0d: got %h want %h", (d == 0) ? "fp" : "rr", t, got, exp);
        end
        // Advance the model across the coming edge
        if (rst) begin
          m_owner[d] = -1; m_last[d] = N - 1; m_outs[d] = 0;
        end else if (o < 0) begin
          if (b_cyc != '0) begin
            int w;
            w = -1;
            for (int k = 1; k <= N; k++) begin
              int j;
              j = (d == 0) ? (k - 1) : ((m_last[d] + k) % N);
              if (w < 0 && b_cyc[j]) w = j;
            end
            m_owner[d] = w;
            m_last[d]  = w;
          end
        end else if (!b_cyc[o]) begin
          m_owner[d] = -1; m_outs[d] = 0;
        end else begin
          m_outs[d] = m_outs[d] + ((e_stb && !b_stall) ? 1 : 0) - ((b_ack && m_outs[d] > 0) ? 1 : 0);
        end
      end
      n_vec++;
      if ({f_din, r_din} !== {{N{b_din}}, {N{b_din}}}) begin
        n_err++;
        $display("FAIL rand_din_t%0d: got %h/%h want %h", t, f_din, r_din, b_din);
      end
      tick();
    end
    rst = 1'b0; b_cyc = '0; b_stb = '0; b_ack = 1'b0; b_pause = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; b_cyc = '0; b_stb = '0; b_we = '0; b_addr = '0; b_dout = '0;
    b_din = '0; b_stall = 1'b0; b_ack = 1'b0; b_pause = 1'b0;
    tick();
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_outstanding_limit();
    test_pause_accept();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
